// File: rtl/pipemem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the debug/loader port, the arbiter and the data memory.
`timescale 1ns/1ps
interface pipemem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_din;
  logic          c_stall;
  logic          c_rvalid;
  logic [DW-1:0] c_dout;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_din;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_dout;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  // Arbiter side: takes requests and memory read data, drives grants, returns and memory controls.
  modport slave (
    input  c_req, c_we, c_addr, c_din, d_req, d_we, d_addr, d_din, mem_dout,
    output c_stall, c_rvalid, c_dout, d_gnt, d_rvalid, d_dout, mem_we, mem_addr, mem_din
  );

  modport master (
    output c_req, c_we, c_addr, c_din, d_req, d_we, d_addr, d_din, mem_dout,
    input  c_stall, c_rvalid, c_dout, d_gnt, d_rvalid, d_dout, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/pipemem_arbiter.sv
// Two-port arbiter (CPU priority, starvation-protected debug port) in front of a
// single-port data memory with registered read data; routes each read result to its owner.
`timescale 1ns/1ps
module pipemem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic             clk,
  input  logic             clrn,
  pipemem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD_C, RD_D} state_t;

  state_t        r_state;
  logic [CW-1:0] r_wcnt;

  logic w_force;
  logic w_winD;
  logic w_winC;

  // Grants are qualified with clrn so nothing reaches memory or the requesters during reset.
  assign w_force = (r_wcnt >= CW'(MAX_WAIT));
  assign w_winD  = clrn & bus.d_req & (~bus.c_req | w_force);
  assign w_winC  = clrn & bus.c_req & ~w_winD;

  assign bus.d_gnt   = w_winD;
  assign bus.c_stall = clrn & bus.c_req & ~w_winC;

  assign bus.mem_we   = w_winD ? bus.d_we   : (w_winC & bus.c_we);
  assign bus.mem_addr = w_winD ? bus.d_addr : bus.c_addr;
  assign bus.mem_din  = w_winD ? bus.d_din  : bus.c_din;

  assign bus.c_rvalid = (r_state == RD_C);
  assign bus.d_rvalid = (r_state == RD_D);
  assign bus.c_dout   = bus.c_rvalid ? bus.mem_dout : '0;
  assign bus.d_dout   = bus.d_rvalid ? bus.mem_dout : '0;

  // Read-owner tracking and debug wait counter; a read granted now returns data next cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
    end else begin
      if (w_winC & ~bus.c_we)
        r_state <= RD_C;
      else if (w_winD & ~bus.d_we)
        r_state <= RD_D;
      else
        r_state <= IDLE;

      if (w_winD | ~bus.d_req)
        r_wcnt <= '0;
      else if (r_wcnt < CW'(MAX_WAIT))
        r_wcnt <= r_wcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipemem_arbiter.sv
// Scoreboard bench for pipemem_arbiter: directed vectors push expected read data,
// a forked monitor pops and compares whenever a read-valid is presented.
`timescale 1ns/1ps
module tb_pipemem_arbiter;

  logic clk = 1'b0;
  logic clrn;
  logic preload;

  always #5 clk = ~clk;

  pipemem_arbiter_if bus();
  pipemem_arbiter_if bus0();

  pipemem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .CW(3)) dut (
    .clk (clk),
    .clrn(clrn),
    .bus (bus)
  );

  pipemem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(0), .CW(3)) dut0 (
    .clk (clk),
    .clrn(clrn),
    .bus (bus0)
  );

  logic [31:0] mem [32];

  // Registered-read memory model; preload seeds the words the vectors read.
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'hA0A0A0A0;
      mem[1] <= 32'h0B0B0B04;
      mem[2] <= 32'h12345678;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[6:2]] <= bus.mem_din;
    end
    bus.mem_dout <= mem[bus.mem_addr[6:2]];
  end

  assign bus0.mem_dout = 32'h0;

  int total;
  int bad;
  logic [31:0] cQ[$];
  logic [31:0] dQ[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cDin, input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dDin);
    bus.c_req  = cReq;
    bus.c_we   = cWe;
    bus.c_addr = cAddr;
    bus.c_din  = cDin;
    bus.d_req  = dReq;
    bus.d_we   = dWe;
    bus.d_addr = dAddr;
    bus.d_din  = dDin;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    clrn    = 1'b0;
    preload = 1'b1;
    bus0.c_req = 1'b0; bus0.c_we = 1'b0; bus0.c_addr = '0; bus0.c_din = '0;
    bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_addr = '0; bus0.d_din = '0;

    fork
      forever begin
        @(negedge clk);
        if (bus.c_rvalid) begin
          if (cQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL c_rvalid_unexpected: got 1 expected 0 (dout %h)", bus.c_dout);
          end else begin
            checkOutput("c_dout", bus.c_dout, cQ.pop_front());
          end
        end else begin
          checkOutput("c_dout_idle", bus.c_dout, 32'h0);
        end
        if (bus.d_rvalid) begin
          if (dQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL d_rvalid_unexpected: got 1 expected 0 (dout %h)", bus.d_dout);
          end else begin
            checkOutput("d_dout", bus.d_dout, dQ.pop_front());
          end
        end else begin
          checkOutput("d_dout_idle", bus.d_dout, 32'h0);
        end
      end
    join_none

    // Reset with both requesters writing: everything must stay quiet.
    applyStimulus(1, 1, 32'h08, 32'h1, 1, 1, 32'h04, 32'h2);
    checkOutput("rst_mem_we",   bus.mem_we,   0);
    checkOutput("rst_c_stall",  bus.c_stall,  0);
    checkOutput("rst_d_gnt",    bus.d_gnt,    0);
    checkOutput("rst_c_rvalid", bus.c_rvalid, 0);
    checkOutput("rst_d_rvalid", bus.d_rvalid, 0);
    checkOutput("rst_c_dout",   bus.c_dout,   0);
    checkOutput("rst_d_dout",   bus.d_dout,   0);
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    clrn    = 1'b1;

    // CPU read of a preloaded word.
    applyStimulus(1, 0, 32'h08, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("rd08_c_stall", bus.c_stall,  0);
    checkOutput("rd08_mem_we",  bus.mem_we,   0);
    checkOutput("rd08_addr",    bus.mem_addr, 32'h08);
    cQ.push_back(32'h12345678);
    nextCycle();

    // CPU write right after the read; the read's data still returns this cycle.
    applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    checkOutput("wr10_mem_we",  bus.mem_we,   1);
    checkOutput("wr10_c_stall", bus.c_stall,  0);
    checkOutput("wr10_din",     bus.mem_din,  32'hDEADBEEF);
    checkOutput("wr10_rvalid",  bus.c_rvalid, 1);
    nextCycle();

    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("rd10_mem_we",     bus.mem_we,   0);
    checkOutput("wr_no_rvalid",    bus.c_rvalid, 0);
    cQ.push_back(32'hDEADBEEF);
    nextCycle();

    // Idle cycle: address follows the CPU port, no write.
    applyStimulus(0, 1, 32'h3C, 32'h5, 0, 0, 32'h0, 32'h0);
    checkOutput("idle_mem_we",  bus.mem_we,   0);
    checkOutput("idle_addr",    bus.mem_addr, 32'h3C);
    checkOutput("idle_c_stall", bus.c_stall,  0);
    nextCycle();

    // CPU hogs the port; debug is force-granted on the 5th and 10th cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 32'h00, 32'h0, 1, 0, 32'h04, 32'h0);
      checkOutput("starve_d_gnt",   bus.d_gnt,   (i == 4 || i == 9) ? 1 : 0);
      checkOutput("starve_c_stall", bus.c_stall, (i == 4 || i == 9) ? 1 : 0);
      if (i == 4 || i == 9) begin
        checkOutput("starve_addr", bus.mem_addr, 32'h04);
        dQ.push_back(32'h0B0B0B04);
      end else begin
        cQ.push_back(32'hA0A0A0A0);
      end
      nextCycle();
    end
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("starve_d_rvalid", bus.d_rvalid, 1);
    nextCycle();

    // Back-to-back reads alternating owners.
    applyStimulus(1, 0, 32'h00, 32'h0, 0, 0, 32'h0, 32'h0);
    cQ.push_back(32'hA0A0A0A0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h04, 32'h0);
    checkOutput("b2b_d_gnt",    bus.d_gnt,    1);
    checkOutput("b2b_c_rvalid", bus.c_rvalid, 1);
    dQ.push_back(32'h0B0B0B04);
    nextCycle();
    applyStimulus(1, 0, 32'h08, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("b2b_c_stall",  bus.c_stall,  0);
    checkOutput("b2b_d_rvalid", bus.d_rvalid, 1);
    cQ.push_back(32'h12345678);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("b2b_c_rvalid2", bus.c_rvalid, 1);
    nextCycle();

    // Reset lands between a read grant and its data edge: the read is dropped.
    applyStimulus(1, 0, 32'h08, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("rstrd_c_stall", bus.c_stall, 0);
    #1;
    clrn = 1'b0;
    #1;
    checkOutput("rstrd_c_stall_low", bus.c_stall,  0);
    checkOutput("rstrd_mem_we",      bus.mem_we,   0);
    checkOutput("rstrd_c_rvalid",    bus.c_rvalid, 0);
    nextCycle();
    checkOutput("rstrd_c_rvalid_edge", bus.c_rvalid, 0);
    checkOutput("rstrd_c_dout_edge",   bus.c_dout,   0);
    clrn = 1'b1;
    @(negedge clk);
    checkOutput("rstrd_resume_stall",  bus.c_stall,  0);
    checkOutput("rstrd_resume_rvalid", bus.c_rvalid, 0);
    cQ.push_back(32'h12345678);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    checkOutput("rstrd_resume_rvalid2", bus.c_rvalid, 1);
    nextCycle();

    // MAX_WAIT = 0 instance: debug wins every cycle it requests.
    for (int i = 0; i < 3; i++) begin
      bus0.c_req = 1'b1; bus0.c_we = 1'b0; bus0.c_addr = 32'h08;
      bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h04;
      @(negedge clk);
      checkOutput("mw0_d_gnt",   bus0.d_gnt,   1);
      checkOutput("mw0_c_stall", bus0.c_stall, 1);
      if (i > 0) checkOutput("mw0_d_rvalid", bus0.d_rvalid, 1);
      nextCycle();
    end
    bus0.d_req = 1'b0;
    @(negedge clk);
    checkOutput("mw0_release_stall",  bus0.c_stall,  0);
    checkOutput("mw0_release_gnt",    bus0.d_gnt,    0);
    checkOutput("mw0_release_rvalid", bus0.d_rvalid, 1);
    nextCycle();
    bus0.c_req = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("c_queue_drained", cQ.size(), 0);
    checkOutput("d_queue_drained", dQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
